// File: rtl/branch_resolve_queue_pkg.sv
// Shared types for the branch resolve queue: one in-flight conditional branch
// per entry, plus the sequential fetch step.
package branch_pkg;

  localparam int BR_XLEN = 32;

  localparam logic [BR_XLEN-1:0] PC_STEP = BR_XLEN'(4);

  typedef struct packed {
    logic [BR_XLEN-1:0] pc;
    logic [BR_XLEN-1:0] target;
    logic               pred;
    logic               dir;
  } brEntry_t;

endpackage

// File: rtl/branch_resolve_queue.sv
// In-order queue of predicted conditional branches; resolves the oldest one in
// execute, producing redirect and predictor-training signals with zero latency.
module branch_resolve_queue
  import branch_pkg::*;
#(
  parameter int DATA_WIDTH = BR_XLEN,
  parameter int DEPTH      = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   PushF,
  input  logic [DATA_WIDTH-1:0]  PCF,
  input  logic [DATA_WIDTH-1:0]  TargetF,
  input  logic                   PredTakenF,
  input  logic                   DirF,
  input  logic                   BranchE,
  input  logic                   ZeroE,
  output logic                   FlushBranch,
  output logic [DATA_WIDTH-1:0]  PCRedirect,
  output logic                   PCRedirectSrc,
  output logic                   TrainValid,
  output logic                   TrainDir,
  output logic                   TrainCorrect,
  output logic                   Full,
  output logic                   Empty,
  output logic [$clog2(DEPTH):0] Count,
  output logic                   Overflow,
  output logic                   Underflow
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  brEntry_t        mem [DEPTH];
  logic [PW-1:0]   head;
  logic [PW-1:0]   tail;
  logic [CW-1:0]   count;
  logic            overflowQ;
  logic            underflowQ;

  brEntry_t        headEntry;
  logic            resolve;
  logic            mispredict;
  logic            push;
  logic            pop;
  logic [BR_XLEN-1:0] redirect;

  assign Empty = (count == '0);
  assign Full  = (count == CW'(DEPTH));

  always_comb begin
    headEntry  = mem[head];
    resolve    = BranchE & ~Empty;
    mispredict = resolve & (headEntry.pred != ZeroE);
    pop        = resolve;
    // A full queue still accepts a push when the head retires correctly.
    push       = PushF & ~mispredict & (~Full | pop);
    redirect   = '0;
    if (mispredict) begin
      redirect = ZeroE ? headEntry.target : headEntry.pc + PC_STEP;
    end
  end

  assign FlushBranch   = mispredict;
  assign PCRedirectSrc = mispredict;
  assign PCRedirect    = DATA_WIDTH'(redirect);
  assign TrainValid    = resolve;
  assign TrainDir      = resolve & headEntry.dir;
  assign TrainCorrect  = resolve & ~mispredict;
  assign Count         = count;
  assign Overflow      = overflowQ;
  assign Underflow     = underflowQ;

  always_ff @(posedge clk) begin
    if (rst) begin
      head       <= '0;
      tail       <= '0;
      count      <= '0;
      overflowQ  <= 1'b0;
      underflowQ <= 1'b0;
    end else begin
      if (PushF && Full && !pop) overflowQ <= 1'b1;
      if (BranchE && Empty) underflowQ <= 1'b1;
      // Everything younger than a mispredicted branch is wrong-path.
      if (mispredict) begin
        head  <= '0;
        tail  <= '0;
        count <= '0;
      end else begin
        if (push) tail <= tail + PW'(1);
        if (pop)  head <= head + PW'(1);
        case ({push, pop})
          2'b10:   count <= count + CW'(1);
          2'b01:   count <= count - CW'(1);
          default: count <= count;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && push) begin
      mem[tail] <= '{pc:     BR_XLEN'(PCF),
                     target: BR_XLEN'(TargetF),
                     pred:   PredTakenF,
                     dir:    DirF};
    end
  end

endmodule

// File: tb/tb_branch_resolve_queue.sv
// Directed bench for branch_resolve_queue: resolution responses checked by a
// scoreboard monitor, occupancy/flags checked inline after each edge.
module tb_branch_resolve_queue;

  logic        clk = 1'b0;
  logic        rst;
  logic        PushF;
  logic [31:0] PCF;
  logic [31:0] TargetF;
  logic        PredTakenF;
  logic        DirF;
  logic        BranchE;
  logic        ZeroE;
  logic        FlushBranch;
  logic [31:0] PCRedirect;
  logic        PCRedirectSrc;
  logic        TrainValid;
  logic        TrainDir;
  logic        TrainCorrect;
  logic        Full;
  logic        Empty;
  logic [2:0]  Count;
  logic        Overflow;
  logic        Underflow;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic        flush;
    logic [31:0] redir;
    logic        src;
    logic        tv;
    logic        tdir;
    logic        tc;
  } resp_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] target;
    logic        pred;
    logic        dir;
  } ent_t;

  resp_t expQ[$];
  ent_t  modelQ[$];

  branch_resolve_queue #(.DATA_WIDTH(32), .DEPTH(4)) dut (
    .clk(clk), .rst(rst), .PushF(PushF), .PCF(PCF), .TargetF(TargetF),
    .PredTakenF(PredTakenF), .DirF(DirF), .BranchE(BranchE), .ZeroE(ZeroE),
    .FlushBranch(FlushBranch), .PCRedirect(PCRedirect), .PCRedirectSrc(PCRedirectSrc),
    .TrainValid(TrainValid), .TrainDir(TrainDir), .TrainCorrect(TrainCorrect),
    .Full(Full), .Empty(Empty), .Count(Count), .Overflow(Overflow), .Underflow(Underflow)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic resp_t mk(input logic flush, input logic [31:0] redir, input logic src,
                               input logic tv, input logic tdir, input logic tc);
    resp_t r;
    r.flush = flush; r.redir = redir; r.src = src; r.tv = tv; r.tdir = tdir; r.tc = tc;
    return r;
  endfunction

  // Monitor: every BranchE cycle the DUT presents a resolution response.
  always @(negedge clk) begin : monitor
    resp_t act;
    resp_t e;
    if (BranchE === 1'b1) begin
      act = mk(FlushBranch, PCRedirect, PCRedirectSrc, TrainValid, TrainDir, TrainCorrect);
      checks++;
      if (expQ.size() == 0) begin
        errors++;
        $display("FAIL resolve: unexpected response %h, no expectation queued", act);
      end else begin
        e = expQ.pop_front();
        if (act !== e) begin
          errors++;
          $display("FAIL resolve: got flush=%b redir=%h src=%b tv=%b tdir=%b tc=%b, need flush=%b redir=%h src=%b tv=%b tdir=%b tc=%b",
                   act.flush, act.redir, act.src, act.tv, act.tdir, act.tc,
                   e.flush, e.redir, e.src, e.tv, e.tdir, e.tc);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    PushF = 1'b0; PCF = '0; TargetF = '0; PredTakenF = 1'b0; DirF = 1'b0;
    BranchE = 1'b0; ZeroE = 1'b0;
  endtask

  task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, need 0x%0h", name, act, req);
    end
  endtask

  task automatic setPush(input logic [31:0] pc, input logic [31:0] t,
                         input logic pred, input logic dir);
    PushF = 1'b1; PCF = pc; TargetF = t; PredTakenF = pred; DirF = dir;
  endtask

  task automatic setResolve(input logic zero, input resp_t e);
    BranchE = 1'b1; ZeroE = zero;
    expQ.push_back(e);
  endtask

  task automatic pushOne(input logic [31:0] pc, input logic [31:0] t,
                         input logic pred, input logic dir);
    setPush(pc, t, pred, dir);
    step();
    idle();
  endtask

  task automatic doReset();
    rst = 1'b1;
    step(); step();
    rst = 1'b0;
  endtask

  ent_t fifo5 [5];

  initial begin
    idle();
    doReset();

    // Reset state
    checkVal("rst_empty", 32'(Empty), 1);
    checkVal("rst_full", 32'(Full), 0);
    checkVal("rst_count", 32'(Count), 0);
    checkVal("rst_ovf", 32'(Overflow), 0);
    checkVal("rst_udf", 32'(Underflow), 0);
    checkVal("rst_outs", {FlushBranch, PCRedirectSrc, TrainValid, TrainDir, TrainCorrect}, 0);
    checkVal("rst_redir", PCRedirect, 0);

    // Correct taken prediction
    pushOne(32'h10, 32'h40, 1'b1, 1'b0);
    checkVal("t1_count", 32'(Count), 1);
    setResolve(1'b1, mk(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b1));
    step(); idle();
    checkVal("t1_empty", 32'(Empty), 1);

    // Predicted taken, actually not taken
    pushOne(32'h10, 32'h40, 1'b1, 1'b1);
    setResolve(1'b0, mk(1'b1, 32'h14, 1'b1, 1'b1, 1'b1, 1'b0));
    step(); idle();
    checkVal("t2_empty", 32'(Empty), 1);

    // Mispredict on oldest of three flushes all, drops simultaneous push
    pushOne(32'h100, 32'h200, 1'b0, 1'b0);
    pushOne(32'h104, 32'h300, 1'b0, 1'b1);
    pushOne(32'h108, 32'h400, 1'b0, 1'b0);
    checkVal("t3_count3", 32'(Count), 3);
    setPush(32'h10C, 32'h500, 1'b1, 1'b1);
    setResolve(1'b1, mk(1'b1, 32'h200, 1'b1, 1'b1, 1'b0, 1'b0));
    step(); idle();
    checkVal("t3_count0", 32'(Count), 0);
    checkVal("t3_empty", 32'(Empty), 1);

    // Overflow and FIFO ordering
    fifo5[0] = '{pc: 32'h1000, target: 32'h2000, pred: 1'b0, dir: 1'b1};
    fifo5[1] = '{pc: 32'h1010, target: 32'h2010, pred: 1'b1, dir: 1'b0};
    fifo5[2] = '{pc: 32'h1020, target: 32'h2020, pred: 1'b0, dir: 1'b0};
    fifo5[3] = '{pc: 32'h1030, target: 32'h2030, pred: 1'b1, dir: 1'b1};
    fifo5[4] = '{pc: 32'h1040, target: 32'h2040, pred: 1'b0, dir: 1'b0};
    for (int i = 0; i < 4; i++) pushOne(fifo5[i].pc, fifo5[i].target, fifo5[i].pred, fifo5[i].dir);
    checkVal("t4_full", 32'(Full), 1);
    checkVal("t4_count4", 32'(Count), 4);
    checkVal("t4_noovf", 32'(Overflow), 0);
    pushOne(fifo5[4].pc, fifo5[4].target, fifo5[4].pred, fifo5[4].dir);
    checkVal("t4_ovf", 32'(Overflow), 1);
    checkVal("t4_count_hold", 32'(Count), 4);
    setResolve(1'b0, mk(1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 1'b1)); step(); idle();
    setResolve(1'b1, mk(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b1)); step(); idle();
    setResolve(1'b0, mk(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b1)); step(); idle();
    checkVal("t4_count1", 32'(Count), 1);
    setResolve(1'b0, mk(1'b1, 32'h1034, 1'b1, 1'b1, 1'b1, 1'b0)); step(); idle();
    checkVal("t4_empty", 32'(Empty), 1);
    checkVal("t4_ovf_sticky", 32'(Overflow), 1);

    // Underflow, then reset clears flags
    setResolve(1'b1, mk(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0));
    step(); idle();
    checkVal("t5_udf", 32'(Underflow), 1);
    checkVal("t5_count", 32'(Count), 0);
    doReset();
    checkVal("t5_udf_clr", 32'(Underflow), 0);
    checkVal("t5_ovf_clr", 32'(Overflow), 0);
    checkVal("t5_empty", 32'(Empty), 1);

    // Steady push+pop at Count=2 across pointer wrap
    for (int i = 0; i < 2; i++) begin
      ent_t n;
      n = '{pc: 32'h3000 + 32'(4 * i), target: 32'h4000 + 32'(4 * i), pred: 1'b1, dir: i[0]};
      modelQ.push_back(n);
      pushOne(n.pc, n.target, n.pred, n.dir);
    end
    for (int k = 0; k < 8; k++) begin
      ent_t n;
      ent_t h;
      n = '{pc: 32'h3000 + 32'(4 * (k + 2)), target: 32'h4000 + 32'(4 * (k + 2)),
            pred: 1'b1, dir: ((k % 3) == 0)};
      h = modelQ.pop_front();
      modelQ.push_back(n);
      setPush(n.pc, n.target, n.pred, n.dir);
      setResolve(1'b1, mk(1'b0, 32'h0, 1'b0, 1'b1, h.dir, 1'b1));
      step(); idle();
      checkVal($sformatf("t6_count_%0d", k), 32'(Count), 2);
    end
    begin
      ent_t h;
      h = modelQ.pop_front();
      setResolve(1'b1, mk(1'b0, 32'h0, 1'b0, 1'b1, h.dir, 1'b1));
      step(); idle();
      h = modelQ.pop_front();
      setResolve(1'b0, mk(1'b1, h.pc + 32'd4, 1'b1, 1'b1, h.dir, 1'b0));
      step(); idle();
    end
    checkVal("t6_empty", 32'(Empty), 1);

    step();
    checks++;
    if (expQ.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d responses outstanding, need 0", expQ.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/branch_resolve_queue.md
BRANCH_RESOLVE_QUEUE -- requirements
Module: branch_resolve_queue

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, address/data width.
REQ-002 SHALL have parameter DEPTH, default 4, entry count; a power of two, at least 2.
REQ-003 SHALL have port clk  in  1  sole clock, all state on rising edge.
REQ-004 SHALL have port rst  in  1  synchronous, active-high reset.
REQ-005 SHALL have port PushF  in  1  a conditional branch was predicted in fetch this cycle.
REQ-006 SHALL have port PCF  in  DATA_WIDTH  fetch PC of the pushed branch.
REQ-007 SHALL have port TargetF  in  DATA_WIDTH  computed branch target of the pushed branch.
REQ-008 SHALL have port PredTakenF  in  1  prediction; 1 = taken.
REQ-009 SHALL have port DirF  in  1  branch direction; 0 = forward, 1 = backward.
REQ-010 SHALL have port BranchE  in  1  the oldest branch resolves in execute this cycle.
REQ-011 SHALL have port ZeroE  in  1  actual outcome; 1 = taken.
REQ-012 SHALL have port FlushBranch  out  1  mispredict; flush the younger pipeline stages.
REQ-013 SHALL have port PCRedirect  out  DATA_WIDTH  corrected fetch PC.
REQ-014 SHALL have port PCRedirectSrc  out  1  select PCRedirect as next PC.
REQ-015 SHALL have ports TrainValid, TrainDir, TrainCorrect  out  1 each  counter-update pulse, direction, and outcome==prediction.
REQ-016 SHALL have ports Full, Empty  out  1 each  occupancy flags.
REQ-017 SHALL have port Count  out  $clog2(DEPTH)+1  occupancy.
REQ-018 SHALL have port Overflow, Underflow  out  1 each  sticky error flags.

Function
REQ-019 SHALL store entries {PC, target, pred, dir} in circular FIFO order, with head/tail pointers wrapping modulo DEPTH.
REQ-020 SHALL write an entry at the tail on a clock edge with PushF=1 when the queue is not full, or is full and popping non-mispredicted in the same cycle.
REQ-021 SHALL pop the head on a clock edge with BranchE=1 and Empty=0.
REQ-022 SHALL produce resolution outputs combinationally in the BranchE cycle, with zero latency.
REQ-023 SHALL drive Mispredict = BranchE & !Empty & (head.pred != ZeroE); FlushBranch = PCRedirectSrc = Mispredict.
REQ-024 SHALL drive PCRedirect as head.target when ZeroE=1, else head.PC + 4 (modulo 2^DATA_WIDTH); 0 when Mispredict=0.
REQ-025 SHALL drive TrainValid = BranchE & !Empty, TrainDir = head.dir, TrainCorrect = !Mispredict.
REQ-026 SHALL clear all entries on a mispredict edge (younger entries are wrong-path), and SHALL drop any simultaneous PushF.
REQ-027 SHALL, on a simultaneous push and pop without mispredict, keep Count unchanged and write the pushed entry.
REQ-028 SHALL, on a push while full without a pop, drop the entry and set Overflow.
REQ-029 SHALL, on BranchE while empty, pop nothing, hold TrainValid=0 and all redirect outputs 0, and set Underflow.
REQ-030 SHALL hold Overflow and Underflow until rst.
REQ-031 SHALL derive Full = (Count==DEPTH) and Empty = (Count==0) from registered state only.

Reset
REQ-032 SHALL, on rst=1 at a clock edge, zero the head, tail and Count and clear Overflow and Underflow; Empty=1, Full=0.
REQ-033 SHALL give rst priority over push, pop and mispredict in the same cycle.
REQ-034 SHALL drive all combinational outputs to 0 while Empty=1 after reset.
REQ-035 SHALL leave entry storage uninitialised; it is never observable while Empty=1.

Structure
REQ-036 SHALL place the entry struct (PC, target, pred, dir) and constant PC_STEP=4 in shared package branch_pkg.
REQ-037 SHALL be self-contained with no sub-modules; storage is a register array, fully synthesizable (no dynamic queues).

Verification
REQ-038 SHALL cover: push {PC=0x10, T=0x40, pred=1}, then BranchE with ZeroE=1 -> FlushBranch=0, TrainValid=1, TrainCorrect=1, Empty=1 next cycle.
REQ-039 SHALL cover: push {PC=0x10, T=0x40, pred=1}, then BranchE with ZeroE=0 -> FlushBranch=1, PCRedirect=0x14, PCRedirectSrc=1.
REQ-040 SHALL cover: push 3 entries (pred=0, 0, 0), BranchE ZeroE=1 on the first, with a simultaneous PushF -> PCRedirect=first.target, Count=0 next cycle.
REQ-041 SHALL cover: push 5 entries with DEPTH=4 -> Full=1 after 4, Overflow=1, Count=4; then pop 4 in order and check FIFO ordering.
REQ-042 SHALL cover: BranchE while empty -> no outputs asserted, Underflow=1; then rst -> Underflow=0, Empty=1.
REQ-043 SHALL cover: queue held at Count=2 with a simultaneous push and correct pop for 8 cycles -> Count stays 2 across pointer wrap.
